// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the MEM stage of an RV32I pipeline. Accepts one
//   load or store at a time, checks it for alignment, range and funct3
//   legality, waits WAIT_CYCLES cycles, then performs the access and presents
//   a one-cycle response. Storage is 2^ADDR_WIDTH little-endian 32-bit words
//   and is not cleared by reset.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req_valid  request strobe from the MEM stage
//   req_ready  high only while idle; a request is taken when both are high
//   mem_ctrl   00 none, 01 load, 10 store, 11 reserved (00/11 are ignored)
//   funct3     RV32I width/sign code
//   addr       byte address
//   wdata      right-aligned store data
//   rsp_valid  one-cycle response strobe
//   rdata      formatted load data, 0 for stores and errors
//   rsp_err    request was rejected
module dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  mem_ctrl,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  state_t state;
  state_t next_state;
  logic [3:0] cnt;
  logic [3:0] next_cnt;

  logic [ADDR_WIDTH+1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [2:0]            lat_funct3;
  logic                  lat_store;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        req_store;
  logic        funct3_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic        done;

  logic [31:0] word;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic [31:0] store_data;

  // Request legality is judged from the live inputs at the acceptance edge,
  // so an error can go straight to RESPOND without touching storage.
  always_comb begin
    req_store    = (mem_ctrl == 2'b10);
    accept       = req_valid && (state == IDLE) &&
                   ((mem_ctrl == 2'b01) || (mem_ctrl == 2'b10));
    if (req_store)
      funct3_bad = (funct3 >= 3'b011);
    else
      funct3_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
    req_err      = funct3_bad || misaligned || out_of_range;
  end

  // State register; the counter tracks how long ACCESS has lasted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic. ACCESS ends on the edge where the counter has seen
  // WAIT_CYCLES cycles, which is also the edge the storage access happens.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = req_err ? RESPOND : ACCESS;
          next_cnt   = 4'd0;
        end
      end
      ACCESS: begin
        if (cnt == LAST_CNT) begin
          done       = 1'b1;
          next_state = RESPOND;
          next_cnt   = 4'd0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      RESPOND: next_state = IDLE;
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESPOND);

  // Load formatting from the latched request; selection is by byte lane
  // within the addressed word.
  always_comb begin
    word = mem[lat_addr[ADDR_WIDTH+1:2]];
    case (lat_addr[1:0])
      2'b00:   byte_lane = word[7:0];
      2'b01:   byte_lane = word[15:8];
      2'b10:   byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = lat_addr[1] ? word[31:16] : word[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_data = {24'd0, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_data = {16'd0, half_lane};
      default: load_data = word;
    endcase
  end

  // Store lane steering: replicate the right-aligned data across the word
  // and let the byte enables pick the lanes that actually change.
  always_comb begin
    case (lat_funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << lat_addr[1:0];
        store_data = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = lat_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{lat_wdata[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = lat_wdata;
      end
    endcase
  end

  // Storage has no reset. A reset during ACCESS forces the state to IDLE
  // immediately, so 'done' cannot fire and a pending store is dropped.
  always_ff @(posedge clk) begin
    if (done && lat_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[lat_addr[ADDR_WIDTH+1:2]][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  // Request latch and registered response. rdata/rsp_err only change on the
  // edge that enters RESPOND and hold their value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
      lat_store  <= 1'b0;
      rdata      <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr   <= addr[ADDR_WIDTH+1:0];
        lat_wdata  <= wdata;
        lat_funct3 <= funct3;
        lat_store  <= req_store;
        if (req_err) begin
          rdata   <= 32'd0;
          rsp_err <= 1'b1;
        end
      end
      if (done) begin
        rdata   <= lat_store ? 32'd0 : load_data;
        rsp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder with WAIT_CYCLES=2. Stimulus tasks push
//   the hand-computed response into a scoreboard queue; a monitor on the
//   falling edge pops and compares every time rsp_valid is seen. Cycle-level
//   handshake and reset behaviour is checked inline with check_output.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  mem_ctrl;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  int checks    = 0;
  int errors    = 0;
  int rsp_count = 0;

  logic [32:0] sb_q [$];

  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] ST = 2'b10;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_ctrl  (mem_ctrl),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [32:0] exp_rsp;
    if (rsp_valid) begin
      rsp_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rsp: got err=%0b rdata=%08h with no request outstanding",
                 rsp_err, rdata);
      end else begin
        exp_rsp = sb_q.pop_front();
        if ({rsp_err, rdata} !== exp_rsp)
          begin
            errors++;
            $display("[TB] FAIL response #%0d: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                     rsp_count, rsp_err, rdata, exp_rsp[32], exp_rsp[31:0]);
          end
      end
    end
  end

  // Inline comparison helper for handshake and reset checks.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
    end
  endtask

  // Drive one request once the DUT is idle, record the expectation, and
  // return #1 after the acceptance edge with the inputs scrambled.
  task automatic issue(input logic [1:0] c, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_e,
                       output int target);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: req_ready still 0 after 50 cycles");
    end
    req_valid = 1'b1;
    mem_ctrl  = c;
    funct3    = f;
    addr      = a;
    wdata     = d;
    sb_q.push_back({exp_e, exp_rd});
    target = rsp_count + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_ctrl  = 2'b10;
    funct3    = 3'b111;
    addr      = 32'hFFFF_FFFF;
    wdata     = 32'hA5A5_A5A5;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (rsp_count < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: response count %0d, expected %0d", rsp_count, target);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] c, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp_rd, input logic exp_e);
    int target;
    issue(c, f, a, d, exp_rd, exp_e, target);
    wait_rsp(target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int target;
    int base;

    reset     = 1'b1;
    req_valid = 1'b0;
    mem_ctrl  = 2'b00;
    funct3    = 3'b000;
    addr      = 32'd0;
    wdata     = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ready",     32'(req_ready), 32'd1);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_rdata",     rdata,          32'd0);
    check_output("reset_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] store/load word with timing");
    apply_stimulus(ST, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(LD, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, target);
    check_output("lw_e0_ready",  32'(req_ready), 32'd0);
    check_output("lw_e0_valid",  32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check_output("lw_e1_ready",  32'(req_ready), 32'd0);
    check_output("lw_e1_valid",  32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check_output("lw_e2_ready",  32'(req_ready), 32'd0);
    check_output("lw_e2_valid",  32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    check_output("lw_e3_ready",  32'(req_ready), 32'd1);
    check_output("lw_e3_valid",  32'(rsp_valid), 32'd0);
    check_output("lw_e3_rdata_held", rdata, 32'hDEAD_BEEF);
    wait_rsp(target);

    $display("[TB] sub-word loads");
    apply_stimulus(LD, 3'b000, 32'h13, 32'd0, 32'hFFFF_FFDE, 1'b0);
    apply_stimulus(LD, 3'b100, 32'h13, 32'd0, 32'h0000_00DE, 1'b0);
    apply_stimulus(LD, 3'b001, 32'h12, 32'd0, 32'hFFFF_DEAD, 1'b0);
    apply_stimulus(LD, 3'b101, 32'h10, 32'd0, 32'h0000_BEEF, 1'b0);

    $display("[TB] sub-word stores");
    apply_stimulus(ST, 3'b000, 32'h11, 32'hAAAA_AA55, 32'd0, 1'b0);
    apply_stimulus(LD, 3'b010, 32'h10, 32'd0, 32'hDEAD_55EF, 1'b0);
    apply_stimulus(ST, 3'b001, 32'h12, 32'hFFFF_1234, 32'd0, 1'b0);
    apply_stimulus(LD, 3'b010, 32'h10, 32'd0, 32'h1234_55EF, 1'b0);

    $display("[TB] top word of storage");
    apply_stimulus(ST, 3'b010, 32'h3FC, 32'h89AB_CDEF, 32'd0, 1'b0);
    apply_stimulus(LD, 3'b000, 32'h3FF, 32'd0, 32'hFFFF_FF89, 1'b0);
    apply_stimulus(LD, 3'b101, 32'h3FC, 32'd0, 32'h0000_CDEF, 1'b0);

    $display("[TB] error cases");
    issue(LD, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1, target);
    check_output("err_e0_valid", 32'(rsp_valid), 32'd1);
    check_output("err_e0_err",   32'(rsp_err),   32'd1);
    check_output("err_e0_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check_output("err_e1_valid", 32'(rsp_valid), 32'd0);
    check_output("err_e1_ready", 32'(req_ready), 32'd1);
    check_output("err_e1_err_held", 32'(rsp_err), 32'd1);
    wait_rsp(target);

    apply_stimulus(ST, 3'b010, 32'h0,   32'h0102_0304, 32'd0, 1'b0);
    apply_stimulus(ST, 3'b010, 32'h400, 32'hFFFF_FFFF, 32'd0, 1'b1);
    apply_stimulus(ST, 3'b100, 32'h0,   32'hFFFF_FFFF, 32'd0, 1'b1);
    apply_stimulus(ST, 3'b001, 32'h1,   32'hFFFF_FFFF, 32'd0, 1'b1);
    apply_stimulus(LD, 3'b011, 32'h0,   32'd0,         32'd0, 1'b1);
    apply_stimulus(LD, 3'b110, 32'h0,   32'd0,         32'd0, 1'b1);
    apply_stimulus(LD, 3'b010, 32'h0,   32'd0, 32'h0102_0304, 1'b0);

    $display("[TB] ignored mem_ctrl codes");
    base = rsp_count;
    @(negedge clk);
    req_valid = 1'b1;
    mem_ctrl  = 2'b00;
    funct3    = 3'b010;
    addr      = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("nop_ready", 32'(req_ready), 32'd1);
      check_output("nop_valid", 32'(rsp_valid), 32'd0);
    end
    mem_ctrl = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("rsv_ready", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    mem_ctrl  = 2'b00;
    check_output("nop_rsp_count", 32'(rsp_count - base), 32'd0);

    $display("[TB] back-to-back loads with req_valid held");
    base = rsp_count;
    @(negedge clk);
    req_valid = 1'b1;
    mem_ctrl  = LD;
    funct3    = 3'b010;
    addr      = 32'h10;
    sb_q.push_back({1'b0, 32'h1234_55EF});
    @(posedge clk);
    sb_q.push_back({1'b0, 32'h1234_55EF});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_output($sformatf("b2b_ready_k%0d", k), 32'(req_ready), (k == 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ctrl  = 2'b00;
    check_output("b2b_second_accept", 32'(req_ready), 32'd0);
    wait_rsp(base + 2);
    repeat (8) @(posedge clk);
    check_output("b2b_rsp_count", 32'(rsp_count - base), 32'd2);

    $display("[TB] reset during ACCESS");
    apply_stimulus(ST, 3'b010, 32'h20, 32'hCAFE_F00D, 32'd0, 1'b0);
    base = rsp_count;
    @(negedge clk);
    req_valid = 1'b1;
    mem_ctrl  = ST;
    funct3    = 3'b010;
    addr      = 32'h20;
    wdata     = 32'h1111_1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ctrl  = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_output("rst_ready",     32'(req_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rdata",     rdata,          32'd0);
    check_output("rst_rsp_err",   32'(rsp_err),   32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_output("rst_no_rsp", 32'(rsp_count - base), 32'd0);
    check_output("rst_ready_after", 32'(req_ready), 32'd1);
    apply_stimulus(LD, 3'b010, 32'h20, 32'd0, 32'hCAFE_F00D, 1'b0);

    repeat (3) @(posedge clk);
    check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: word-index width; storage is 2^ADDR_WIDTH 32-bit words (1 KiB at default).
REQ-002 Parameter WAIT_CYCLES, default 2, legal 1..15: access latency in cycles for a valid request.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  MEM-stage access request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 mem_ctrl  input  2  operation: 00 none, 01 load, 10 store, 11 reserved.
REQ-008 funct3  input  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-009 addr  input  32  byte address, little-endian.
REQ-010 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rdata  output  32  formatted load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request rejected: misaligned, out of range, or illegal funct3.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS and RESPOND; req_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL occur at an edge where req_valid=1, req_ready=1 and mem_ctrl is 01 or 10; mem_ctrl 00 or 11 SHALL be ignored with no state change.
REQ-016 On acceptance, addr, wdata, funct3 and mem_ctrl SHALL be latched; later input changes SHALL have no effect on the request.
REQ-017 An accepted request SHALL be flagged as an error if any of these holds:
- halfword with addr[0]=1
- word with addr[1:0]!=00
- addr[31:ADDR_WIDTH+2]!=0
- load funct3 in {011,110,111}
- store funct3 >= 011
REQ-018 On error, the FSM SHALL go IDLE->RESPOND at the acceptance edge E0, giving rsp_valid=1, rsp_err=1 and rdata=0 in the cycle after E0; no storage write SHALL occur.
REQ-019 Valid requests SHALL go IDLE->ACCESS at E0; a 4-bit counter SHALL hold ACCESS for WAIT_CYCLES cycles, and the FSM SHALL enter RESPOND at edge E0+WAIT_CYCLES.
REQ-020 Stores SHALL write storage at edge E0+WAIT_CYCLES using byte enables:
- SB: byte addr[1:0]
- SH: bytes 2*addr[1] and 2*addr[1]+1
- SW: all four bytes
Unselected bytes SHALL be preserved.
REQ-021 Loads SHALL read word addr[ADDR_WIDTH+1:2]:
- LB/LBU: byte addr[1:0], sign- or zero-extended
- LH/LHU: half addr[1], sign- or zero-extended
- LW: full word
REQ-022 A load issued after a store completes SHALL return the post-store data.
REQ-023 RESPOND SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; the earliest next acceptance is edge E0+WAIT_CYCLES+2 (valid) or E0+2 (error).
REQ-024 rdata and rsp_err SHALL be registered, updated only on entry to RESPOND, and held otherwise.
REQ-025 req_valid held high while busy SHALL NOT be accepted until IDLE, and no request SHALL be lost or duplicated.

Reset
REQ-026 While reset=1, the outputs SHALL be: state IDLE, counter 0, req_ready=1, rsp_valid=0, rdata=0, rsp_err=0.
REQ-027 Reset SHALL NOT clear storage contents.
REQ-028 Reset asserted during ACCESS SHALL abort the request; a store whose write edge has not occurred SHALL leave storage unchanged, and no response SHALL be issued.

Verification (WAIT_CYCLES=2)
REQ-029 SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, rsp_err=0; rsp_valid high for exactly one cycle after edge E0+2; req_ready=0 from E0 to E0+3.
REQ-030 With word 0x10=0xDEADBEEF:
- LB @0x13 -> 0xFFFFFFDE
- LBU @0x13 -> 0x000000DE
- LH @0x12 -> 0xFFFFDEAD
- LHU @0x10 -> 0x0000BEEF
REQ-031 SB 0x55 @0x11 -> LW @0x10 = 0xDEAD55EF; then SH 0x1234 @0x12 -> LW @0x10 = 0x123455EF.
REQ-032 Error cases:
- LW @0x12 -> rsp_err=1, rdata=0, rsp_valid one cycle after E0
- SW 0xFFFFFFFF @0x400 -> rsp_err=1; LW @0x0 returns the prior value unchanged
REQ-033 Handshake cases:
- req_valid=1 with mem_ctrl=00 for 5 cycles -> no rsp_valid, req_ready stays 1
- req_valid held high across two back-to-back loads -> exactly two responses, second acceptance at E0+4
REQ-034 Reset cases:
- SW 0x11111111 @0x20, then reset pulse one cycle after E0 -> no rsp_valid, outputs at reset values; LW @0x20 returns the prior value unchanged
